// File: rtl/mux_arb_nx1_if.sv
// Channel bundle for mux_arb_nx1: N flattened input channels in, one registered word out.
// The slave modport is the mux's view; master is the view of whatever drives it.
interface mux_arb_nx1_if #(
   parameter int WIDTH = 32,
   parameter int N     = 4
);
   localparam int SW = (N > 1) ? $clog2(N) : 1;

   logic [N*WIDTH-1:0] I;
   logic [N-1:0]       IV;
   logic [N-1:0]       IR;
   logic [SW-1:0]      S;
   logic [WIDTH-1:0]   Y;
   logic               YV;
   logic               YR;
   logic [SW-1:0]      G;

   modport master (
      output I, IV, S, YR,
      input  IR, Y, YV, G
   );

   modport slave (
      input  I, IV, S, YR,
      output IR, Y, YV, G
   );
endinterface

// File: rtl/mux_arb_nx1.sv
// N:1 channel mux with a single registered output stage.
// MODE 0 selects by S; MODE 1 grants round-robin, starting after the last granted channel.
module mux_arb_nx1 #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int MODE  = 0
) (
   input  logic         CLK,
   input  logic         RSTn,
   mux_arb_nx1_if.slave bus
);
   localparam int          SW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned NU = N;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [SW-1:0]    g_q, g_d;
   logic [SW-1:0]    ptr_q, ptr_d;

   logic [SW-1:0]    cand;
   logic             cand_vld;
   logic             cand_iv;
   logic [WIDTH-1:0] cand_data;
   logic [N-1:0]     ir_vec;
   logic             slot_open;
   logic             in_xfer;
   logic             out_xfer;

   assign slot_open = (state_q == ST_EMPTY) | bus.YR;
   assign out_xfer  = (state_q == ST_FULL) & bus.YR;

   always_comb begin : cand_sel
      logic           found;
      int unsigned    idx;
      logic [SW-1:0]  idx_s;
      cand     = '0;
      cand_vld = 1'b0;
      found    = 1'b0;
      idx      = 0;
      idx_s    = '0;
      if (MODE == 0) begin
         cand     = bus.S;
         cand_vld = (32'(bus.S) < NU);
      end else begin
         // Search (ptr+1) mod N upward with wrap; first valid channel wins.
         for (int unsigned off = 1; off <= NU; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= NU) idx = idx - NU;
            idx_s = SW'(idx);
            if (!found && bus.IV[idx_s]) begin
               found = 1'b1;
               cand  = idx_s;
            end
         end
         cand_vld = found;
      end
   end

   always_comb begin : cand_mux
      cand_data = '0;
      cand_iv   = 1'b0;
      ir_vec    = '0;
      for (int unsigned k = 0; k < NU; k++) begin
         if (cand == SW'(k)) begin
            cand_data = bus.I[k*WIDTH +: WIDTH];
            cand_iv   = bus.IV[k];
            ir_vec[k] = slot_open & cand_vld;
         end
      end
   end

   assign in_xfer = cand_vld & cand_iv & slot_open;

   always_comb begin : next_state
      state_d = state_q;
      y_d     = y_q;
      g_d     = g_q;
      ptr_d   = ptr_q;
      if (in_xfer) begin
         state_d = ST_FULL;
         y_d     = cand_data;
         g_d     = cand;
         if (MODE == 1) ptr_d = cand;
      end else if (out_xfer) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= ST_EMPTY;
         y_q     <= '0;
         g_q     <= '0;
         ptr_q   <= SW'(N - 1);
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.Y  = y_q;
   assign bus.YV = (state_q == ST_FULL);
   assign bus.G  = g_q;
   assign bus.IR = ir_vec;
endmodule

// File: tb/tb_mux_arb_nx1.sv
// Bench for mux_arb_nx1: one MODE 0 and one MODE 1 instance against a transaction-level model,
// plus directed literal expectations.
module tb_mux_arb_nx1;
   localparam int W  = 32;
   localparam int NC = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux_arb_nx1_if #(.WIDTH(W), .N(NC)) b0 ();
   mux_arb_nx1_if #(.WIDTH(W), .N(NC)) b1 ();

   mux_arb_nx1 #(.WIDTH(W), .N(NC), .MODE(0)) dut0 (.CLK(clk), .RSTn(rst_n), .bus(b0));
   mux_arb_nx1 #(.WIDTH(W), .N(NC), .MODE(1)) dut1 (.CLK(clk), .RSTn(rst_n), .bus(b1));

   int checks = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   typedef struct packed {
      logic [31:0] y;
      logic        yv;
      logic [1:0]  g;
      logic [1:0]  ptr;
   } ms_t;

   ms_t m0, m1;

   function automatic ms_t rst_ms();
      ms_t r;
      r.y = '0; r.yv = 1'b0; r.g = '0; r.ptr = 2'd3;
      return r;
   endfunction

   // Returns the channel that would be granted, or -1 for none.
   function automatic int pick(int mode, logic [1:0] s, logic [3:0] iv, logic [1:0] ptr);
      int k;
      if (mode == 0) return (int'(s) < NC) ? int'(s) : -1;
      for (int off = 1; off <= NC; off++) begin
         k = (int'(ptr) + off) % NC;
         if (iv[k]) return k;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_ir(ms_t m, int mode, logic [1:0] s, logic [3:0] iv, logic yr);
      logic [3:0] r;
      int c;
      r = '0;
      c = pick(mode, s, iv, m.ptr);
      if ((!m.yv || yr) && c >= 0) r[c] = 1'b1;
      return r;
   endfunction

   function automatic ms_t step(ms_t m, int mode, logic [1:0] s, logic [3:0] iv, logic yr,
                                logic [127:0] data);
      ms_t n;
      int c;
      n = m;
      c = pick(mode, s, iv, m.ptr);
      if (c >= 0 && iv[c] && (!m.yv || yr)) begin
         n.y  = data[c*32 +: 32];
         n.g  = 2'(c);
         n.yv = 1'b1;
         if (mode == 1) n.ptr = 2'(c);
      end else if (m.yv && yr) begin
         n.yv = 1'b0;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0 <= rst_ms();
         m1 <= rst_ms();
      end else begin
         m0 <= step(m0, 0, b0.S, b0.IV, b0.YR, b0.I);
         m1 <= step(m1, 1, b1.S, b1.IV, b1.YR, b1.I);
      end
   end

   always @(negedge clk) begin
      chk("m0_y",  64'(b0.Y),  64'(m0.y));
      chk("m0_yv", 64'(b0.YV), 64'(m0.yv));
      chk("m0_g",  64'(b0.G),  64'(m0.g));
      chk("m0_ir", 64'(b0.IR), 64'(exp_ir(m0, 0, b0.S, b0.IV, b0.YR)));
      chk("m1_y",  64'(b1.Y),  64'(m1.y));
      chk("m1_yv", 64'(b1.YV), 64'(m1.yv));
      chk("m1_g",  64'(b1.G),  64'(m1.g));
      chk("m1_ir", 64'(b1.IR), 64'(exp_ir(m1, 1, b1.S, b1.IV, b1.YR)));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int seq_a [5] = '{0, 1, 2, 3, 0};
   int seq_b [4] = '{1, 3, 1, 3};

   initial begin
      b0.I = '0; b0.IV = '0; b0.S = '0; b0.YR = 1'b0;
      b1.I = '0; b1.IV = '0; b1.S = '0; b1.YR = 1'b0;
      #1;
      chk("rst_y0",  64'(b0.Y),  64'd0);
      chk("rst_yv0", 64'(b0.YV), 64'd0);
      chk("rst_ir0", 64'(b0.IR), 64'b0001);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // MODE 0: single word on channel 1
      b0.S = 2'd1; b0.IV = 4'b0010; b0.I[32 +: 32] = 32'h2; b0.YR = 1'b1;
      #1 chk("m0_ir_pre", 64'(b0.IR), 64'b0010);
      tick();
      chk("m0_y_first",  64'(b0.Y),  64'h2);
      chk("m0_yv_first", 64'(b0.YV), 64'd1);
      chk("m0_g_first",  64'(b0.G),  64'd1);
      chk("m0_ir_first", 64'(b0.IR), 64'b0010);
      b0.I[32 +: 32] = 32'h4;
      tick();
      chk("m0_y_four", 64'(b0.Y), 64'h4);

      // MODE 0: backpressure while S toggles
      b0.YR = 1'b0; b0.IV = 4'b1111;
      b0.I = {32'hC3, 32'hC2, 32'hC1, 32'h5};
      for (int i = 0; i < 3; i++) begin
         b0.S = (i == 1) ? 2'd1 : 2'd0;
         #1 chk("m0_hold_ir", 64'(b0.IR), 64'd0);
         tick();
         chk("m0_hold_y",  64'(b0.Y),  64'h4);
         chk("m0_hold_g",  64'(b0.G),  64'd1);
         chk("m0_hold_yv", 64'(b0.YV), 64'd1);
      end
      b0.S = 2'd0; b0.YR = 1'b1;
      #1 chk("m0_release_ir", 64'(b0.IR), 64'b0001);
      tick();
      chk("m0_reload_y", 64'(b0.Y), 64'h5);
      chk("m0_reload_g", 64'(b0.G), 64'd0);

      // MODE 0: sustained stream on channel 2
      b0.S = 2'd2;
      for (int i = 0; i < 4; i++) begin
         b0.I[64 +: 32] = 32'(i);
         tick();
         chk("m0_stream_y",  64'(b0.Y),  64'(i));
         chk("m0_stream_yv", 64'(b0.YV), 64'd1);
         chk("m0_stream_g",  64'(b0.G),  64'd2);
      end
      b0.IV = 4'b0000;
      #1 chk("m0_ir_no_iv", 64'(b0.IR), 64'b0100);
      tick();
      chk("m0_drain_yv", 64'(b0.YV), 64'd0);
      chk("m0_drain_y",  64'(b0.Y),  64'h3);
      b0.YR = 1'b0;

      // MODE 1: rotation from reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      b1.I = {32'hA3, 32'hA2, 32'hA1, 32'hA0}; b1.IV = 4'b1111; b1.YR = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("m1_rot_g", 64'(b1.G), 64'(seq_a[i]));
         chk("m1_rot_y", 64'(b1.Y), 64'(32'hA0 + seq_a[i]));
      end
      b1.IV = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("m1_alt_g", 64'(b1.G), 64'(seq_b[i]));
      end

      // MODE 1: single requester, then idle
      b1.IV = 4'b0100;
      tick();
      chk("m1_one_g",  64'(b1.G),  64'd2);
      chk("m1_one_yv", 64'(b1.YV), 64'd1);
      b1.IV = 4'b0000;
      tick();
      chk("m1_idle_yv", 64'(b1.YV), 64'd0);
      chk("m1_idle_g",  64'(b1.G),  64'd2);
      chk("m1_idle_y",  64'(b1.Y),  64'hA2);

      // MODE 1: backpressure holds grant and pointer
      b1.IV = 4'b1111; b1.YR = 1'b0;
      tick();
      chk("m1_bp_g", 64'(b1.G), 64'd3);
      for (int i = 0; i < 2; i++) begin
         #1 chk("m1_bp_ir", 64'(b1.IR), 64'd0);
         tick();
         chk("m1_bp_hold_g", 64'(b1.G), 64'd3);
      end
      b1.YR = 1'b1;
      tick();
      chk("m1_bp_next_g", 64'(b1.G), 64'd0);

      // MODE 1: async reset between edges discards held word
      b1.I[64 +: 32] = 32'h8000_0002; b1.IV = 4'b0100;
      tick();
      chk("m1_pre_rst_y", 64'(b1.Y), 64'h8000_0002);
      chk("m1_pre_rst_g", 64'(b1.G), 64'd2);
      b1.YR = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("m1_arst_y",  64'(b1.Y),  64'd0);
      chk("m1_arst_yv", 64'(b1.YV), 64'd0);
      chk("m1_arst_g",  64'(b1.G),  64'd0);
      chk("m1_arst_ir", 64'(b1.IR), 64'b0100);
      tick();
      rst_n = 1'b1; b1.IV = 4'b1111; b1.YR = 1'b1;
      tick();
      chk("m1_post_rst_g",  64'(b1.G),  64'd0);
      chk("m1_post_rst_y",  64'(b1.Y),  64'hA0);
      chk("m1_post_rst_yv", 64'(b1.YV), 64'd1);
      tick();
      chk("m1_post_rst_g2", 64'(b1.G), 64'd1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/mux_arb_nx1.md
MUX_ARB_NX1 -- requirements
Module: mux_arb_nx1

Interface
REQ-001 Parameter WIDTH, default 32: data width of every input channel and of Y.
REQ-002 Parameter N, default 4, legal 2..16: number of input channels.
REQ-003 Parameter MODE, default 0: 0 = explicit select via S; 1 = round-robin arbitration, S ignored.
REQ-004 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-005 CLK  input  1  clock; all state updates on rising edge.
REQ-006 RSTn  input  1  asynchronous active-low reset.
REQ-007 I  input  N*WIDTH  flattened channel data; channel k = I[k*WIDTH +: WIDTH].
REQ-008 IV  input  N  per-channel valid.
REQ-009 IR  output  N  per-channel ready (combinational).
REQ-010 S  input  SW = max(1, clog2(N))  channel select, MODE 0 only.
REQ-011 Y  output  WIDTH  registered output data.
REQ-012 YV  output  1  Y holds valid data.
REQ-013 YR  input  1  downstream ready.
REQ-014 G  output  SW  index of the channel whose data is in Y.

Function
REQ-015 Single output register stage; "slot open" = ~YV | YR.
REQ-016 Candidate channel c: MODE 0: c = S, and no candidate if S >= N; MODE 1: the first k with IV[k]=1, searching from (PTR+1) mod N upward with wrap-around.
REQ-017 IR[k] SHALL be 1 only for k = c, and only when the slot is open; all other IR bits are 0. IR SHALL NOT depend on IV[k] in MODE 0.
REQ-018 An input transfer occurs when IV[c] & IR[c]; on that edge Y <= channel c data, G <= c, YV <= 1.
REQ-019 An output transfer occurs when YV & YR; if there is no input transfer on the same edge, YV <= 0, and Y and G hold their values.
REQ-020 When an output transfer and an input transfer fall on the same edge, the register SHALL reload: one word per cycle sustained, no bubble.
REQ-021 When YV=1 and YR=0, Y, G and YV SHALL stay stable and all IR bits SHALL be 0; changes on S or IV SHALL have no effect on held data.
REQ-022 Latency: data presented on an accepted cycle SHALL appear on Y one cycle later.
REQ-023 MODE 1: PTR <= c on every input transfer only; PTR SHALL hold while there is no transfer.
REQ-024 MODE 1 fairness: with all IV high and YR high, grants SHALL rotate 0,1,..,N-1,0,..
REQ-025 If no channel is valid, or S >= N in MODE 0, no transfer occurs and YV falls after the pending output transfer.
REQ-026 There SHALL be no combinational path from I to Y. The paths from IV, S and YR to IR are combinational.

Reset
REQ-027 While RSTn=0: Y=0, YV=0, G=0, and PTR=N-1, so the first MODE 1 grant search starts at channel 0; IR evaluates with the slot open.
REQ-028 Reset asserted mid-transfer SHALL discard the held word immediately, without waiting for a clock edge.
REQ-029 After RSTn deasserts, the first transfer is permitted on the first rising edge.

Verification (WIDTH=32, N=4)
REQ-030 MODE 0, S=1, IV=4'b0010, ch1=32'h0000_0002, YR=1 -> one edge later Y=32'h0000_0002, YV=1, G=1; IR=4'b0010 throughout.
REQ-031 MODE 0, YV=1 with Y=32'h0000_0004, YR=0; S toggles 0->1->0 for 3 cycles -> Y stays 32'h0000_0004, IR=0; YR=1 -> word accepted, next word loads the same edge.
REQ-032 MODE 0, S=2, IV=4'b1111, YR=1 for 4 cycles with ch2 incrementing 0,1,2,3 -> Y shows 0,1,2,3 on consecutive cycles (no bubble).
REQ-033 MODE 1, IV=4'b1111, YR=1 from reset -> G sequence 0,1,2,3,0; IV=4'b1010 -> G alternates 1,3.
REQ-034 MODE 1, IV=4'b0100 only, then IV=0 -> G=2, YV=1 for one cycle, then YV=0 with Y and G held.
REQ-035 RSTn pulled low between edges while YV=1, Y=32'h8000_0002 -> Y=0, YV=0, G=0 immediately; after release, with IV=4'b1111, the first MODE 1 grant is channel 0.
